// File: rtl/mips_fetch_unit.sv
// MIPS IF stage: owns the PC, drives a single-outstanding instruction-memory
// port, absorbs hazard stalls in a one-entry skid buffer, and redirects fetch
// on branch / jump / jr while dropping wrong-path words still in flight.
module mips_fetch_unit #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pc_src,
  input  logic            flush,
  input  logic            id_stall,
  input  logic [PC_W-1:0] id_pc4,
  input  logic [15:0]     id_imm,
  input  logic [25:0]     id_jaddr,
  input  logic [PC_W-1:0] id_rs_val,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [31:0]     if_id_instr,
  output logic [PC_W-1:0] if_id_pc4,
  output logic            if_id_valid,
  output logic [PC_W-1:0] pc
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] SRC_SEQ    = 2'd0;
  localparam logic [1:0] SRC_BRANCH = 2'd1;
  localparam logic [1:0] SRC_JUMP   = 2'd2;
  localparam logic [1:0] SRC_JR     = 2'd3;

  localparam logic [PC_W-1:0] WORD_MASK = ~PC_W'(3);

  state_t          state;
  logic            discard;     // next imem_valid belongs to a wrong-path request
  logic [PC_W-1:0] stale_addr;  // address of that wrong-path request, kept on the bus
  logic [31:0]     skid_instr;
  logic [PC_W-1:0] skid_pc4;

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] target;
  logic            redirect;
  logic            redirect_bubble;

  // The memory sees a request only in FETCH; while a wrong-path request is
  // still in flight its address stays on the bus until the word comes back.
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = (discard ? stale_addr : pc) & WORD_MASK;
  assign pc_plus4  = pc + PC_W'(4);

  // Next-PC target selection from the decoder's select.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    target = pc_plus4;
    unique case (pc_src)
      SRC_BRANCH: target = id_pc4 + {{(PC_W-18){id_imm[15]}}, id_imm, 2'b00};
      SRC_JUMP:   target = {id_pc4[PC_W-1:28], id_jaddr, 2'b00};
      SRC_JR:     target = id_rs_val & WORD_MASK;
      default:    target = pc_plus4;
    endcase
  end

  assign redirect        = !id_stall && (pc_src != SRC_SEQ);
  assign redirect_bubble = (pc_src != SRC_BRANCH) || flush;

  // Fetch FSM, PC, skid buffer and IF/ID register; priority stall > redirect > accept.
  // NOTE: all state here is assigned non-blocking so every read sees the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      discard     <= 1'b0;
      stale_addr  <= '0;
      skid_instr  <= '0;
      skid_pc4    <= '0;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: state <= S_FETCH;

        S_FETCH: begin
          if (id_stall) begin
            // IF/ID and PC hold; a returning word is parked in the skid buffer.
            if (imem_valid) begin
              if (discard) begin
                discard <= 1'b0;
              end else begin
                skid_instr <= imem_rdata;
                skid_pc4   <= pc_plus4;
                state      <= S_HOLD;
              end
            end
          end else if (redirect) begin
            pc <= target;
            if (redirect_bubble) begin
              if_id_instr <= '0;
              if_id_valid <= 1'b0;
            end
            if (imem_valid) begin
              // Whatever returns this cycle is on the wrong path; the bus is free.
              discard <= 1'b0;
            end else begin
              discard <= 1'b1;
              if (!discard) stale_addr <= pc;
            end
          end else begin
            if (flush) begin
              if_id_instr <= '0;
              if_id_valid <= 1'b0;
            end
            if (imem_valid) begin
              if (discard) begin
                discard <= 1'b0;
              end else begin
                if_id_instr <= imem_rdata;
                if_id_pc4   <= pc_plus4;
                if_id_valid <= 1'b1;
                pc          <= pc_plus4;
              end
            end
          end
        end

        S_HOLD: begin
          if (!id_stall) begin
            state      <= S_FETCH;
            skid_instr <= '0;
            skid_pc4   <= '0;
            if (redirect) begin
              pc <= target;
              if (redirect_bubble) begin
                if_id_instr <= '0;
                if_id_valid <= 1'b0;
              end
            end else begin
              if_id_instr <= skid_instr;
              if_id_pc4   <= skid_pc4;
              if_id_valid <= 1'b1;
              pc          <= skid_pc4;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: a latency-programmable memory
// model returns rdata = address, and a scoreboard queue holds the
// instructions expected to enter IF/ID, in order.
module tb_mips_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic        flush;
  logic        id_stall;
  logic [31:0] id_pc4;
  logic [15:0] id_imm;
  logic [25:0] id_jaddr;
  logic [31:0] id_rs_val;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [31:0] pc;

  mips_fetch_unit #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_src      (pc_src),
    .flush       (flush),
    .id_stall    (id_stall),
    .id_pc4      (id_pc4),
    .id_imm      (id_imm),
    .id_jaddr    (id_jaddr),
    .id_rs_val   (id_rs_val),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory model: answers after `lat` wait cycles; rdata mirrors the address.
  int lat = 0;
  int wait_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    wait_cnt <= 0;
    else if (!imem_req || imem_valid) wait_cnt <= 0;
    else                           wait_cnt <= wait_cnt + 1;
  end
  assign imem_valid = imem_req && (wait_cnt >= lat);
  assign imem_rdata = imem_addr;

  // Scoreboard of instructions expected to enter IF/ID.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t sb_q[$];

  // IF/ID holds a freshly delivered instruction when it is valid after an unstalled edge.
  logic stall_at_edge;
  always @(posedge clk) stall_at_edge <= id_stall;

  always @(negedge clk) begin
    if (rst_n && !stall_at_edge && if_id_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_instr", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_instr", if_id_instr, e.instr);
        check("sb_pc4",   if_id_pc4,   e.pc4);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc4);
    exp_t e;
    e.instr = instr;
    e.pc4   = pc4;
    sb_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit found;
    rst_n     = 1'b0;
    pc_src    = 2'd0;
    flush     = 1'b0;
    id_stall  = 1'b0;
    id_pc4    = '0;
    id_imm    = '0;
    id_jaddr  = '0;
    id_rs_val = '0;
    lat       = 0;

    // Reset held for three cycles.
    repeat (3) step();
    check("rst_if_id_valid", if_id_valid, 1'b0);
    check("rst_imem_req",    imem_req,    1'b0);
    check("rst_if_id_instr", if_id_instr, 32'h0);
    check("rst_if_id_pc4",   if_id_pc4,   32'h0);
    check("rst_pc",          pc,          32'h0);

    // Release: one IDLE cycle, then the first request at address 0.
    rst_n = 1'b1;
    check("idle_imem_req",    imem_req,    1'b0);
    check("idle_if_id_valid", if_id_valid, 1'b0);
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4), 32'(i * 4 + 4));
    step();
    check("first_req",  imem_req,  1'b1);
    check("first_addr", imem_addr, 32'h0);

    // Zero-latency stream: 0,4,8,C enter IF/ID on consecutive edges.
    repeat (4) step();
    check("stream_pc", pc, 32'h10);

    // Branch back by two words with flush.
    pc_src = 2'd1; flush = 1'b1; id_pc4 = 32'h10; id_imm = 16'hFFFE;
    push_exp(32'h8, 32'hC);
    step();
    pc_src = 2'd0; flush = 1'b0;
    check("branch_addr",   imem_addr,   32'h8);
    check("branch_bubble", if_id_valid, 1'b0);
    step();

    // Jump keeps the top nibble of id_pc4.
    pc_src = 2'd2; id_pc4 = 32'h4000_0010; id_jaddr = 26'h100;
    push_exp(32'h4000_0400, 32'h4000_0404);
    step();
    pc_src = 2'd0;
    check("jump_addr",   imem_addr,   32'h4000_0400);
    check("jump_bubble", if_id_valid, 1'b0);
    step();

    // jr clears the low two bits of rs.
    pc_src = 2'd3; id_rs_val = 32'h123;
    push_exp(32'h120, 32'h124);
    step();
    pc_src = 2'd0;
    check("jr_addr",   imem_addr,   32'h120);
    check("jr_bubble", if_id_valid, 1'b0);
    step();

    // Latency-3 memory, redirect to 0x80 in the first cycle of a fetch of 0x124.
    lat = 3;
    pc_src = 2'd3; id_rs_val = 32'h80;
    push_exp(32'h80, 32'h84);
    step();
    pc_src = 2'd0;
    check("late_redirect_pc",      pc,          32'h80);
    check("late_stale_addr_held",  imem_addr,   32'h124);
    check("late_redirect_bubble",  if_id_valid, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (if_id_valid) found = 1'b1;
    end
    check("late_target_arrived", found, 1'b1);

    // Word returns while the hazard unit stalls for four cycles.
    id_stall = 1'b1;
    lat = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_if_id_instr", if_id_instr, 32'h80);
      check("stall_if_id_valid", if_id_valid, 1'b1);
      check("stall_pc",          pc,          32'h84);
      check("stall_imem_req",    imem_req,    1'b0);
    end
    push_exp(32'h84, 32'h88);
    id_stall = 1'b0;
    step();
    id_stall = 1'b1;
    check("unstall_pc",    pc,          32'h88);
    check("unstall_instr", if_id_instr, 32'h84);
    repeat (3) step();
    check("unstall_no_dup", if_id_instr, 32'h84);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
